cpu_io_bridge: RTL and testbench

- Host-side peripheral at the far end of the risc_v core's 32-bit I/O port.
- Drains CPUOut writes into an output FIFO that a host/bench consumer pops over a valid/ready stream.
- Sources CPUIn from an input FIFO that a host producer fills over a valid/ready stream.
- Decouples CPU I/O timing from the external environment and flags lost data with sticky error bits.

---
 rtl/cpu_io_bridge.sv | 160 ++++++++++++++++
 tb/tb_cpu_io_bridge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_bridge.sv
// cpu_io_bridge: host-side end of the CPU 32-bit I/O port.
// CPU writes (CPUOut/OutWE) are queued in an output FIFO drained by a host
// valid/ready stream; a host valid/ready stream fills an input FIFO whose
// head is presented on CPUIn and popped by InRE. When the input FIFO is
// empty, CPUIn holds the last popped word, which lets polling software
// treat the port as a hold register. Lost data raises sticky error flags.
module cpu_io_bridge #(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] IN_DEFAULT = 32'h0000000F
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [WIDTH-1:0]         CPUOut,
  input  logic                     OutWE,
  output logic [WIDTH-1:0]         CPUIn,
  input  logic                     InRE,
  output logic [WIDTH-1:0]         HostOutData,
  output logic                     HostOutValid,
  input  logic                     HostOutReady,
  input  logic [WIDTH-1:0]         HostInData,
  input  logic                     HostInValid,
  output logic                     HostInReady,
  output logic [$clog2(DEPTH):0]   OutCount,
  output logic [$clog2(DEPTH):0]   InCount,
  output logic                     OutOverflow,
  output logic                     InUnderflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Storage and pointers (extra MSB on each pointer is the wrap bit)
  logic [WIDTH-1:0] out_mem_q [DEPTH];
  logic [WIDTH-1:0] out_mem_d [DEPTH];
  logic [WIDTH-1:0] in_mem_q  [DEPTH];
  logic [WIDTH-1:0] in_mem_d  [DEPTH];
  logic [PW-1:0]    out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
  logic [PW-1:0]    in_wptr_q,  in_wptr_d,  in_rptr_q,  in_rptr_d;
  logic [WIDTH-1:0] last_in_q,  last_in_d;
  logic             out_ovf_q,  out_ovf_d;
  logic             in_udf_q,   in_udf_d;

  // Status and handshake decode
  logic             out_full_s, out_empty_s, in_full_s, in_empty_s;
  logic             out_push_s, out_pop_s, in_push_s, in_pop_s;
  logic [WIDTH-1:0] out_head_s, in_head_s;

  // FIFO status decode from the registered pointers only
  always_comb begin
    out_empty_s = (out_wptr_q == out_rptr_q);
    out_full_s  = (out_wptr_q[AW-1:0] == out_rptr_q[AW-1:0]) &&
                  (out_wptr_q[AW] != out_rptr_q[AW]);
    in_empty_s  = (in_wptr_q == in_rptr_q);
    in_full_s   = (in_wptr_q[AW-1:0] == in_rptr_q[AW-1:0]) &&
                  (in_wptr_q[AW] != in_rptr_q[AW]);
    out_head_s  = out_mem_q[out_rptr_q[AW-1:0]];
    in_head_s   = in_mem_q[in_rptr_q[AW-1:0]];
  end

  // Push/pop qualification; a full output FIFO still accepts a write when the host pops in the same cycle
  always_comb begin
    out_pop_s  = !out_empty_s && HostOutReady;
    out_push_s = OutWE && (!out_full_s || out_pop_s);
    in_push_s  = HostInValid && !in_full_s;
    in_pop_s   = InRE && !in_empty_s;
  end

  // Next-state computation for pointers, storage, hold register and sticky flags
  always_comb begin
    out_wptr_d = out_wptr_q;
    out_rptr_d = out_rptr_q;
    in_wptr_d  = in_wptr_q;
    in_rptr_d  = in_rptr_q;
    out_mem_d  = out_mem_q;
    in_mem_d   = in_mem_q;
    last_in_d  = last_in_q;
    out_ovf_d  = out_ovf_q;
    in_udf_d   = in_udf_q;
    if (out_push_s) begin
      out_mem_d[out_wptr_q[AW-1:0]] = CPUOut;
      out_wptr_d = out_wptr_q + PTR_ONE;
    end else begin
      out_wptr_d = out_wptr_q;
    end
    if (out_pop_s) begin
      out_rptr_d = out_rptr_q + PTR_ONE;
    end else begin
      out_rptr_d = out_rptr_q;
    end
    if (OutWE && !out_push_s) begin
      out_ovf_d = 1'b1;
    end else begin
      out_ovf_d = out_ovf_q;
    end
    if (in_push_s) begin
      in_mem_d[in_wptr_q[AW-1:0]] = HostInData;
      in_wptr_d = in_wptr_q + PTR_ONE;
    end else begin
      in_wptr_d = in_wptr_q;
    end
    if (in_pop_s) begin
      in_rptr_d = in_rptr_q + PTR_ONE;
      last_in_d = in_head_s;
    end else begin
      in_rptr_d = in_rptr_q;
      last_in_d = last_in_q;
    end
    if (InRE && in_empty_s) begin
      in_udf_d = 1'b1;
    end else begin
      in_udf_d = in_udf_q;
    end
  end

  // Control state: pointers, hold register and sticky flags, cleared asynchronously
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      out_wptr_q <= {PW{1'b0}};
      out_rptr_q <= {PW{1'b0}};
      in_wptr_q  <= {PW{1'b0}};
      in_rptr_q  <= {PW{1'b0}};
      last_in_q  <= IN_DEFAULT;
      out_ovf_q  <= 1'b0;
      in_udf_q   <= 1'b0;
    end else begin
      out_wptr_q <= out_wptr_d;
      out_rptr_q <= out_rptr_d;
      in_wptr_q  <= in_wptr_d;
      in_rptr_q  <= in_rptr_d;
      last_in_q  <= last_in_d;
      out_ovf_q  <= out_ovf_d;
      in_udf_q   <= in_udf_d;
    end
  end

  // FIFO data arrays; contents are qualified by the pointers so need no reset
  always_ff @(posedge CLK) begin
    out_mem_q <= out_mem_d;
    in_mem_q  <= in_mem_d;
  end

  // Output drive; CPUIn falls back to the hold register when no input word is queued
  always_comb begin
    HostOutData  = out_head_s;
    HostOutValid = !out_empty_s;
    HostInReady  = !in_full_s;
    OutCount     = out_wptr_q - out_rptr_q;
    InCount      = in_wptr_q - in_rptr_q;
    OutOverflow  = out_ovf_q;
    InUnderflow  = in_udf_q;
    if (in_empty_s) begin
      CPUIn = last_in_q;
    end else begin
      CPUIn = in_head_s;
    end
  end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed self-checking bench for cpu_io_bridge (WIDTH=32, DEPTH=4).
module tb_cpu_io_bridge;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] CPUOut;
  logic        OutWE;
  logic [31:0] CPUIn;
  logic        InRE;
  logic [31:0] HostOutData;
  logic        HostOutValid;
  logic        HostOutReady;
  logic [31:0] HostInData;
  logic        HostInValid;
  logic        HostInReady;
  logic [2:0]  OutCount;
  logic [2:0]  InCount;
  logic        OutOverflow;
  logic        InUnderflow;

  int total = 0;
  int bad   = 0;

  cpu_io_bridge #(.WIDTH(32), .DEPTH(4), .IN_DEFAULT(32'h0000000F)) dut (
    .CLK(CLK), .Reset(Reset), .CPUOut(CPUOut), .OutWE(OutWE), .CPUIn(CPUIn),
    .InRE(InRE), .HostOutData(HostOutData), .HostOutValid(HostOutValid),
    .HostOutReady(HostOutReady), .HostInData(HostInData),
    .HostInValid(HostInValid), .HostInReady(HostInReady),
    .OutCount(OutCount), .InCount(InCount), .OutOverflow(OutOverflow),
    .InUnderflow(InUnderflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cpuin"},  CPUIn, 32'h0000000F);
    check({tag, "_ovalid"}, 32'(HostOutValid), 32'd0);
    check({tag, "_iready"}, 32'(HostInReady), 32'd1);
    check({tag, "_ocount"}, 32'(OutCount), 32'd0);
    check({tag, "_icount"}, 32'(InCount), 32'd0);
    check({tag, "_ovf"},    32'(OutOverflow), 32'd0);
    check({tag, "_udf"},    32'(InUnderflow), 32'd0);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    step();
  endtask

  initial begin
    Reset = 1'b0; CPUOut = 32'd0; OutWE = 1'b0; InRE = 1'b0;
    HostOutReady = 1'b0; HostInData = 32'd0; HostInValid = 1'b0;
    repeat (2) step();
    check_idle("in_reset");
    Reset = 1'b1;
    step();
    check_idle("idle");

    // CPU writes 1,2,3, host not ready
    OutWE = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      CPUOut = 32'(i);
      step();
    end
    OutWE = 1'b0;
    check("ocount3", 32'(OutCount), 32'd3);
    check("ohead1", HostOutData, 32'd1);
    HostOutReady = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      check("odrain_valid", 32'(HostOutValid), 32'd1);
      check("odrain_data", HostOutData, 32'(i));
      step();
    end
    HostOutReady = 1'b0;
    check("odrain_empty", 32'(HostOutValid), 32'd0);

    // Overflow: 10..14 into a 4-deep FIFO, 14 dropped
    OutWE = 1'b1;
    for (int i = 10; i <= 14; i++) begin
      CPUOut = 32'(i);
      step();
    end
    OutWE = 1'b0;
    check("ovf_count", 32'(OutCount), 32'd4);
    check("ovf_flag", 32'(OutOverflow), 32'd1);
    HostOutReady = 1'b1;
    for (int i = 10; i <= 13; i++) begin
      check("ovf_drain", HostOutData, 32'(i));
      step();
    end
    HostOutReady = 1'b0;
    check("ovf_empty", 32'(HostOutValid), 32'd0);
    check("ovf_sticky", 32'(OutOverflow), 32'd1);

    // Same with a host pop on the fifth write: 14 accepted, no overflow
    do_reset();
    check("rst_ovf_clear", 32'(OutOverflow), 32'd0);
    OutWE = 1'b1;
    for (int i = 10; i <= 13; i++) begin
      CPUOut = 32'(i);
      step();
    end
    CPUOut = 32'd14;
    HostOutReady = 1'b1;
    step();
    OutWE = 1'b0;
    check("fullpop_count", 32'(OutCount), 32'd4);
    check("fullpop_ovf", 32'(OutOverflow), 32'd0);
    for (int i = 11; i <= 14; i++) begin
      check("fullpop_drain", HostOutData, 32'(i));
      step();
    end
    HostOutReady = 1'b0;
    check("fullpop_empty", 32'(HostOutValid), 32'd0);

    // Input path: host pushes A5, 5A; CPU pops and then underflows
    HostInValid = 1'b1;
    HostInData = 32'h000000A5;
    step();
    HostInData = 32'h0000005A;
    step();
    HostInValid = 1'b0;
    check("in_count2", 32'(InCount), 32'd2);
    check("in_head_a5", CPUIn, 32'h000000A5);
    InRE = 1'b1; step(); InRE = 1'b0;
    check("in_head_5a", CPUIn, 32'h0000005A);
    check("in_count1", 32'(InCount), 32'd1);
    InRE = 1'b1; step(); InRE = 1'b0;
    check("in_hold_5a", CPUIn, 32'h0000005A);
    check("in_count0", 32'(InCount), 32'd0);
    check("in_udf0", 32'(InUnderflow), 32'd0);
    InRE = 1'b1; step(); InRE = 1'b0;
    check("in_udf1", 32'(InUnderflow), 32'd1);
    check("in_udf_hold", CPUIn, 32'h0000005A);
    check("in_udf_count", 32'(InCount), 32'd0);

    // Wrap and concurrency: prefill 2 in each FIFO, then stream 20 words
    do_reset();
    OutWE = 1'b1; HostInValid = 1'b1;
    CPUOut = 32'd100; HostInData = 32'd200;
    step();
    CPUOut = 32'd101; HostInData = 32'd201;
    step();
    HostOutReady = 1'b1; InRE = 1'b1;
    for (int i = 0; i < 20; i++) begin
      CPUOut = 32'(102 + i);
      HostInData = 32'(202 + i);
      check("wrap_odata", HostOutData, 32'(100 + i));
      check("wrap_cpuin", CPUIn, 32'(200 + i));
      step();
      check("wrap_ocount", 32'(OutCount), 32'd2);
      check("wrap_icount", 32'(InCount), 32'd2);
    end
    OutWE = 1'b0; HostInValid = 1'b0; HostOutReady = 1'b0; InRE = 1'b0;
    check("wrap_ohead", HostOutData, 32'd120);
    check("wrap_ihead", CPUIn, 32'd220);

    // Async reset between edges with both FIFOs holding 2 words
    #2;
    Reset = 1'b0;
    #1;
    check_idle("async_rst");
    #1;
    Reset = 1'b1;
    step();
    check_idle("post_rst");
    HostInValid = 1'b1; HostInData = 32'h00000077;
    OutWE = 1'b1; CPUOut = 32'h00000055;
    step();
    HostInValid = 1'b0; OutWE = 1'b0;
    check("post_cpuin", CPUIn, 32'h00000077);
    check("post_icount", 32'(InCount), 32'd1);
    check("post_odata", HostOutData, 32'h00000055);
    check("post_ocount", 32'(OutCount), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
